// File: rtl/bench_comb_bist_if.sv
// Bundle between the BIST tester and its environment: run control, CUT stimulus/response and status.
// The master side is the tester itself; the slave side is whoever starts runs and hosts the CUT.
interface bench_comb_bist_if #(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned OUT_W = 7
);
    logic             i_start;
    logic             i_pause;
    logic [IN_W-1:0]  o_cut_in;
    logic [OUT_W-1:0] i_cut_out;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic [OUT_W-1:0] o_signature;
    logic [15:0]      o_pat_cnt;

    modport master (
        input  i_start,
        input  i_pause,
        input  i_cut_out,
        output o_cut_in,
        output o_busy,
        output o_done,
        output o_pass,
        output o_signature,
        output o_pat_cnt
    );

    modport slave (
        output i_start,
        output i_pause,
        output i_cut_out,
        input  o_cut_in,
        input  o_busy,
        input  o_done,
        input  o_pass,
        input  o_signature,
        input  o_pat_cnt
    );
endinterface

// File: rtl/bench_comb_bist.sv
// LFSR-driven pattern source and MISR response compactor for a combinational benchmark core.
// A run applies PATTERNS patterns, then compares the final signature against GOLDEN.
module bench_comb_bist #(
    parameter int unsigned     IN_W      = 36,
    parameter int unsigned     OUT_W     = 7,
    parameter int unsigned     PATTERNS  = 1024,
    parameter logic [IN_W-1:0] LFSR_SEED = 36'h000000001,
    parameter logic [OUT_W-1:0] MISR_SEED = 7'h00,
    parameter logic [OUT_W-1:0] GOLDEN    = 7'h00
) (
    input  logic                clk,
    input  logic                rst,
    bench_comb_bist_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(PATTERNS - 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [IN_W-1:0]   r_lfsr;
    logic [OUT_W-1:0]  r_misr;
    logic [15:0]       r_patCnt;
    logic              r_pass;

    logic              w_load;
    logic              w_advance;
    logic              w_last;
    logic [IN_W-1:0]   w_lfsrNext;
    logic [OUT_W-1:0]  w_misrNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // start is only honoured outside RUN, so a run can only be cut short by rst
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    w_stateNext = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (!bus.i_pause) begin
                    w_advance = 1'b1;
                    if (r_patCnt == LAST_CNT) begin
                        w_last      = 1'b1;
                        w_stateNext = DONE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        w_lfsrNext = {r_lfsr[IN_W-2:0], r_lfsr[IN_W-1] ^ r_lfsr[24]};
        w_misrNext = {r_misr[OUT_W-2:0], r_misr[OUT_W-1] ^ r_misr[OUT_W-2]} ^ bus.i_cut_out;
    end

    // On the final absorb the LFSR stays put so cut_in keeps showing the last pattern in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= LFSR_SEED;
            r_misr   <= MISR_SEED;
            r_patCnt <= 16'd0;
            r_pass   <= 1'b0;
        end else if (w_load) begin
            r_lfsr   <= LFSR_SEED;
            r_misr   <= MISR_SEED;
            r_patCnt <= 16'd0;
            r_pass   <= 1'b0;
        end else if (w_advance) begin
            r_misr   <= w_misrNext;
            r_patCnt <= r_patCnt + 16'd1;
            if (w_last) begin
                r_pass <= (w_misrNext == GOLDEN);
            end else begin
                r_lfsr <= w_lfsrNext;
            end
        end
    end

    assign bus.o_cut_in    = r_lfsr;
    assign bus.o_signature = r_misr;
    assign bus.o_pat_cnt   = r_patCnt;
    assign bus.o_pass      = r_pass;
    assign bus.o_busy      = (r_state == RUN);
    assign bus.o_done      = (r_state == DONE);

endmodule
